// File: rtl/median_line_buffer.sv
// ---------------------------------------------------------------------------
// median_line_buffer
//
// Upstream feeder for the median filter pipeline. Takes a raster pixel
// stream (one pixel per accepted beat) and emits, one cycle later, the
// vertical 3-pixel column for the same column index:
//   a_o = row n-2, b_o = row n-1, c_o = row n (current pixel).
// Two line memories hold the previous two rows. They are not reset; a
// row-fill state machine masks their stale contents until both hold data
// from the current frame.
//
// Optional build macro: BORDER_REPLICATE_EN
//   undefined : rows 0 and 1 produce no output (top border cropped).
//   defined   : rows 0 and 1 produce output with the missing rows
//               replicated from the oldest available row.
//
// Ports
//   clk1_i        clock, all state on rising edge
//   rst_i         asynchronous, active-high reset
//   pix_in_i      incoming pixel, bit 0 = MSB
//   pix_valid_i   pix_in_i accepted this cycle (no backpressure)
//   sof_i         start of frame, qualified by pix_valid_i
//   a_o/b_o/c_o   column output rows n-2 / n-1 / n
//   out_valid_o   single-cycle pulse, a_o/b_o/c_o hold a valid column
//   out_col_o     column index of the emitted column
//   out_last_o    emitted column is the last of its line
// ---------------------------------------------------------------------------
module median_line_buffer #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk1_i,
    input  logic              rst_i,
    input  logic [0:PIX_W-1]  pix_in_i,
    input  logic              pix_valid_i,
    input  logic              sof_i,
    output logic [0:PIX_W-1]  a_o,
    output logic [0:PIX_W-1]  b_o,
    output logic [0:PIX_W-1]  c_o,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_col_o,
    output logic              out_last_o
);

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [0:PIX_W-1]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ocol_q, ocol_d;
    logic              last_q, last_d;

    logic [0:PIX_W-1]  l1_mem [IMG_W];
    logic [0:PIX_W-1]  l2_mem [IMG_W];

    // Effective column/state for this beat: sof re-anchors to (row 0, col 0)
    // before the beat is processed, overriding any wrap in the same cycle.
    logic              sof_beat;
    logic [ADDR_W-1:0] col_x;
    state_e            state_x;
    logic              wrap;
    logic [0:PIX_W-1]  l1_rd, l2_rd;

    assign sof_beat = pix_valid_i & sof_i;
    assign col_x    = sof_beat ? '0 : col_q;
    assign state_x  = sof_beat ? FILL0 : state_q;
    assign wrap     = (col_x == LAST_COL);
    assign l1_rd    = l1_mem[col_x];
    assign l2_rd    = l2_mem[col_x];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        valid_d = 1'b0;
        ocol_d  = ocol_q;
        last_d  = last_q;
        if (pix_valid_i) begin
            col_d = wrap ? '0 : col_x + ADDR_W'(1);
            if (wrap) begin
                case (state_x)
                    FILL0:   state_d = FILL1;
                    FILL1:   state_d = STREAM;
                    default: state_d = STREAM;
                endcase
            end else begin
                state_d = state_x;
            end

            case (state_x)
                STREAM: begin
                    valid_d = 1'b1;
                    a_d     = l2_rd;
                    b_d     = l1_rd;
                    c_d     = pix_in_i;
                end
`ifdef BORDER_REPLICATE_EN
                FILL0: begin
                    valid_d = 1'b1;
                    a_d     = pix_in_i;
                    b_d     = pix_in_i;
                    c_d     = pix_in_i;
                end
                FILL1: begin
                    valid_d = 1'b1;
                    a_d     = l1_rd;
                    b_d     = l1_rd;
                    c_d     = pix_in_i;
                end
`endif
                default: ;
            endcase

            // Column tag only tracks emitted columns so it holds alongside A/B/C.
            if (valid_d) begin
                ocol_d = col_x;
                last_d = wrap;
            end
        end
    end

    always_ff @(posedge clk1_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL0;
            col_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            ocol_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            ocol_q  <= ocol_d;
            last_q  <= last_d;
        end
    end

    // Line memories: read-before-write, shifting the column down one row.
    always_ff @(posedge clk1_i) begin
        if (pix_valid_i) begin
            l2_mem[col_x] <= l1_rd;
            l1_mem[col_x] <= pix_in_i;
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign c_o         = c_q;
    assign out_valid_o = valid_q;
    assign out_col_o   = ocol_q;
    assign out_last_o  = last_q;

endmodule

// File: tb/tb_median_line_buffer.sv
module tb_median_line_buffer;

    localparam int PIX_W  = 8;
    localparam int IMG_W  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic [PIX_W-1:0]  pix_in;
    logic              pix_valid;
    logic              sof;
    logic [PIX_W-1:0]  a, b, c;
    logic              out_valid;
    logic [ADDR_W-1:0] out_col;
    logic              out_last;

    int n_checks = 0;
    int n_pass   = 0;

    // expected-output model state
    logic [7:0] e_a, e_b, e_c;
    logic       e_valid, e_last;
    logic [1:0] e_col;

    median_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk1_i      (clk),
        .rst_i       (rst),
        .pix_in_i    (pix_in),
        .pix_valid_i (pix_valid),
        .sof_i       (sof),
        .a_o         (a),
        .b_o         (b),
        .c_o         (c),
        .out_valid_o (out_valid),
        .out_col_o   (out_col),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one accepted beat for frame position (r, c) with pixel {r,c},
    // then advance the expected outputs by hand-derived rules.
    task automatic send(input int r, input int cc, input bit s);
        logic [3:0] r4, c4, rm2, rm1;
        r4  = r[3:0];
        c4  = cc[3:0];
        rm1 = r4 - 4'd1;
        rm2 = r4 - 4'd2;
        pix_in    = {r4, c4};
        pix_valid = 1'b1;
        sof       = s;
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
        if (r >= 2) begin
            e_valid = 1'b1;
            e_a = {rm2, c4}; e_b = {rm1, c4}; e_c = {r4, c4};
            e_col = cc[1:0]; e_last = (cc == IMG_W - 1);
        end else begin
`ifdef BORDER_REPLICATE_EN
            e_valid = 1'b1;
            e_a = (r == 0) ? {r4, c4} : {4'h0, c4};
            e_b = e_a;
            e_c = {r4, c4};
            e_col = cc[1:0]; e_last = (cc == IMG_W - 1);
`else
            e_valid = 1'b0;
`endif
        end
    endtask

    task automatic idle(input bit s);
        pix_valid = 1'b0;
        sof       = s;
        @(posedge clk);
        @(negedge clk);
        sof     = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        sof = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, a, b, c, out_col, out_last} !== 28'h0) begin
            $display("FAIL reset_during: got v=%b a=%h b=%h c=%h col=%0d last=%b, want all zero",
                     out_valid, a, b, c, out_col, out_last);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        e_valid = 0; e_a = 0; e_b = 0; e_c = 0; e_col = 0; e_last = 0;
        idle(1'b0);
        n_checks++;
        if ({out_valid, a, b, c, out_col, out_last} !== 28'h0) begin
            $display("FAIL reset_after: got v=%b a=%h b=%h c=%h col=%0d last=%b, want all zero",
                     out_valid, a, b, c, out_col, out_last);
        end else n_pass++;
    endtask

    // Rows 0-1 of a frame; first beat carries sof when s=1.
    task automatic test_fill(input bit s);
        for (int r = 0; r < 2; r++) begin
            for (int cc = 0; cc < IMG_W; cc++) begin
                send(r, cc, s && r == 0 && cc == 0);
                n_checks++;
                if ({out_valid, a, b, c, out_col, out_last} !== {e_valid, e_a, e_b, e_c, e_col, e_last}) begin
                    $display("FAIL fill r%0d c%0d: got v=%b a=%h b=%h c=%h col=%0d last=%b, want v=%b a=%h b=%h c=%h col=%0d last=%b",
                             r, cc, out_valid, a, b, c, out_col, out_last, e_valid, e_a, e_b, e_c, e_col, e_last);
                end else n_pass++;
`ifdef BORDER_REPLICATE_EN
                if (r == 0 && cc == 0) begin
                    n_checks++;
                    if ({out_valid, a, b, c} !== {1'b1, 8'h00, 8'h00, 8'h00}) begin
                        $display("FAIL repl_r0c0: got v=%b a=%h b=%h c=%h, want v=1 a=00 b=00 c=00", out_valid, a, b, c);
                    end else n_pass++;
                end
                if (r == 1 && cc == 2) begin
                    n_checks++;
                    if ({out_valid, a, b, c} !== {1'b1, 8'h02, 8'h02, 8'h12}) begin
                        $display("FAIL repl_r1c2: got v=%b a=%h b=%h c=%h, want v=1 a=02 b=02 c=12", out_valid, a, b, c);
                    end else n_pass++;
                end
`else
                n_checks++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL fill_novalid r%0d c%0d: got %b want 0", r, cc, out_valid);
                end else n_pass++;
`endif
            end
        end
    endtask

    task automatic test_stream;
        for (int r = 2; r < 5; r++) begin
            for (int cc = 0; cc < IMG_W; cc++) begin
                if (r == 4 && cc > 0) break;
                send(r, cc, 1'b0);
                n_checks++;
                if ({out_valid, a, b, c, out_col, out_last} !== {e_valid, e_a, e_b, e_c, e_col, e_last}) begin
                    $display("FAIL stream r%0d c%0d: got v=%b a=%h b=%h c=%h col=%0d last=%b, want v=%b a=%h b=%h c=%h col=%0d last=%b",
                             r, cc, out_valid, a, b, c, out_col, out_last, e_valid, e_a, e_b, e_c, e_col, e_last);
                end else n_pass++;
                if (r == 2 && cc == 1) begin
                    n_checks++;
                    if ({out_valid, a, b, c, out_col} !== {1'b1, 8'h01, 8'h11, 8'h21, 2'd1}) begin
                        $display("FAIL r2c1_literal: got v=%b a=%h b=%h c=%h col=%0d, want v=1 a=01 b=11 c=21 col=1",
                                 out_valid, a, b, c, out_col);
                    end else n_pass++;
                end
                if (r == 3 && cc == 3) begin
                    n_checks++;
                    if ({a, b, c, out_last} !== {8'h13, 8'h23, 8'h33, 1'b1}) begin
                        $display("FAIL r3c3_literal: got a=%h b=%h c=%h last=%b, want a=13 b=23 c=33 last=1",
                                 a, b, c, out_last);
                    end else n_pass++;
                end
                if (r == 4) begin
                    n_checks++;
                    if ({out_valid, a, out_last} !== {1'b1, 8'h20, 1'b0}) begin
                        $display("FAIL r4c0_wrap: got v=%b a=%h last=%b, want v=1 a=20 last=0", out_valid, a, out_last);
                    end else n_pass++;
                end
            end
        end
    endtask

    task automatic test_gap;
        test_fill(1'b1);
        send(2, 0, 1'b0);
        send(2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            n_checks++;
            if ({out_valid, a, b, c, out_col} !== {1'b0, 8'h01, 8'h11, 8'h21, 2'd1}) begin
                $display("FAIL gap_hold %0d: got v=%b a=%h b=%h c=%h col=%0d, want v=0 a=01 b=11 c=21 col=1",
                         i, out_valid, a, b, c, out_col);
            end else n_pass++;
        end
        for (int cc = 2; cc < IMG_W; cc++) begin
            send(2, cc, 1'b0);
            n_checks++;
            if ({out_valid, a, b, c, out_col, out_last} !== {e_valid, e_a, e_b, e_c, e_col, e_last}) begin
                $display("FAIL gap_resume c%0d: got v=%b a=%h b=%h c=%h col=%0d last=%b, want v=%b a=%h b=%h c=%h col=%0d last=%b",
                         cc, out_valid, a, b, c, out_col, out_last, e_valid, e_a, e_b, e_c, e_col, e_last);
            end else n_pass++;
        end
    endtask

    task automatic test_sof_ignored;
        send(3, 0, 1'b0);
        idle(1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL sof_novalid_pulse: got v=%b want 0", out_valid);
        end else n_pass++;
        send(3, 1, 1'b0);
        n_checks++;
        if ({out_valid, a, b, c, out_col} !== {1'b1, 8'h11, 8'h21, 8'h31, 2'd1}) begin
            $display("FAIL sof_ignored: got v=%b a=%h b=%h c=%h col=%0d, want v=1 a=11 b=21 c=31 col=1",
                     out_valid, a, b, c, out_col);
        end else n_pass++;
    endtask

    // Row 3 col 2 slot carries sof: new frame (row 0, col 0) starts there.
    task automatic test_sof_mid;
        test_fill(1'b1);
        send(2, 0, 1'b0);
        n_checks++;
        if ({out_valid, a, b, c, out_col} !== {1'b1, 8'h00, 8'h10, 8'h20, 2'd0}) begin
            $display("FAIL sof_mid_first: got v=%b a=%h b=%h c=%h col=%0d, want v=1 a=00 b=10 c=20 col=0",
                     out_valid, a, b, c, out_col);
        end else n_pass++;
    endtask

    task automatic test_reset_mid;
        send(2, 1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, a, b, c, out_col, out_last} !== 28'h0) begin
            $display("FAIL reset_mid: got v=%b a=%h b=%h c=%h col=%0d last=%b, want all zero",
                     out_valid, a, b, c, out_col, out_last);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        e_valid = 0; e_a = 0; e_b = 0; e_c = 0; e_col = 0; e_last = 0;
        test_fill(1'b0);
        for (int cc = 0; cc < IMG_W; cc++) begin
            send(2, cc, 1'b0);
            n_checks++;
            if ({out_valid, a, b, c, out_col, out_last} !== {e_valid, e_a, e_b, e_c, e_col, e_last}) begin
                $display("FAIL after_reset r2 c%0d: got v=%b a=%h b=%h c=%h col=%0d last=%b, want v=%b a=%h b=%h c=%h col=%0d last=%b",
                         cc, out_valid, a, b, c, out_col, out_last, e_valid, e_a, e_b, e_c, e_col, e_last);
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0;
        pix_in = '0;
        pix_valid = 1'b0;
        sof = 1'b0;
        test_reset();
        test_fill(1'b1);
        test_stream();
        test_gap();
        test_sof_ignored();
        test_sof_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
